// File: rtl/clk_div_gen_pkg.sv
// Shared definitions for the programmable clock-waveform generator: channel FSM
// encodings and the field-offset helper used to slice the packed per-channel buses.
package clk_div_gen_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  // Low bit of channel idx's field in a bus packed as NCH fields of width w.
  function automatic int fld_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/clk_div_gen_channel.sv
// One output channel: run/stop FSM, period counter, shadowed settings and the
// registered D0/D1 half-slot pair; outputs lag the counter state by one edge.
module clk_div_gen_channel
  import clk_div_gen_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_sync,
  input  logic [DW-1:0] i_div,
  input  logic [DW:0]   i_hi,
  input  logic [DW-1:0] i_ph,
  input  logic          i_inv,
  output logic          o_d0,
  output logic          o_d1,
  output logic          o_running,
  output logic          o_wrap
);

  logic [1:0]    r_state;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_div;
  logic [DW:0]   r_hi;
  logic          r_inv;
  logic          r_d0;
  logic          r_d1;
  logic          r_wrap;

  logic          w_wrap;
  logic          w_raw0;
  logic          w_raw1;
  logic [DW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_ph_eff;

  assign w_wrap    = (r_cnt == r_div);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + DW'(1);
  // An out-of-range phase would start the counter above its wrap point.
  assign w_ph_eff  = (i_ph <= i_div) ? i_ph : '0;
  assign w_raw0    = ({r_cnt, 1'b0} < r_hi);
  assign w_raw1    = ({r_cnt, 1'b1} < r_hi);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_hi    <= '0;
      r_inv   <= 1'b0;
      r_d0    <= 1'b0;
      r_d1    <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_d0   <= (r_state == ST_IDLE) ? r_inv : (w_raw0 ^ r_inv);
      r_d1   <= (r_state == ST_IDLE) ? r_inv : (w_raw1 ^ r_inv);
      r_wrap <= (r_state != ST_IDLE) && w_wrap;
      case (r_state)
        ST_IDLE: begin
          r_inv <= i_inv;
          if (i_en) begin
            r_div   <= i_div;
            r_hi    <= i_hi;
            r_cnt   <= w_ph_eff;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_sync) begin
            r_div <= i_div;
            r_hi  <= i_hi;
            r_inv <= i_inv;
            r_cnt <= w_ph_eff;
            if (!i_en) r_state <= ST_STOPPING;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_wrap) begin
              r_div <= i_div;
              r_hi  <= i_hi;
              r_inv <= i_inv;
            end
            // A stop request landing on the last slot has nothing left to finish.
            if (!i_en) r_state <= w_wrap ? ST_IDLE : ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          r_cnt <= w_cnt_nxt;
          if (w_wrap) begin
            r_div   <= i_div;
            r_hi    <= i_hi;
            r_inv   <= i_inv;
            r_state <= i_en ? ST_RUN : ST_IDLE;
          end else if (i_en) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_d0      = r_d0;
  assign o_d1      = r_d1;
  assign o_wrap    = r_wrap;
  assign o_running = (r_state != ST_IDLE);

endmodule

// File: rtl/clk_div_gen.sv
// N-channel programmable clock-waveform generator feeding ODDR2 pads from FSBCLK.
// Slices the packed configuration buses per channel and fans out SYNC.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 4
) (
  input  logic                  FSBCLK,
  input  logic                  nRES,
  input  logic [NCH-1:0]        EN,
  input  logic                  SYNC,
  input  logic [NCH*DW-1:0]     DIV,
  input  logic [NCH*(DW+1)-1:0] HI,
  input  logic [NCH*DW-1:0]     PH,
  input  logic [NCH-1:0]        INV,
  output logic [NCH-1:0]        D0,
  output logic [NCH-1:0]        D1,
  output logic [NCH-1:0]        RUNNING,
  output logic [NCH-1:0]        WRAP
);

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      clk_div_gen_channel #(
        .DW(DW)
      ) u_ch (
        .i_clk    (FSBCLK),
        .i_rst_n  (nRES),
        .i_en     (EN[g]),
        .i_sync   (SYNC),
        .i_div    (DIV[fld_lo(g, DW) +: DW]),
        .i_hi     (HI[fld_lo(g, DW + 1) +: DW + 1]),
        .i_ph     (PH[fld_lo(g, DW) +: DW]),
        .i_inv    (INV[g]),
        .o_d0     (D0[g]),
        .o_d1     (D1[g]),
        .o_running(RUNNING[g]),
        .o_wrap   (WRAP[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_gen.sv
// Scenario bench for clk_div_gen: per-cycle expected {D0,D1,WRAP,RUNNING} queued and compared.
module tb_clk_div_gen;

  logic        FSBCLK = 1'b0;
  logic        nRES   = 1'b0;
  logic        SYNC   = 1'b0;
  logic [3:0]  EN     = '0;
  logic [3:0]  INV    = '0;
  logic [15:0] DIV    = '0;
  logic [15:0] PH     = '0;
  logic [19:0] HI     = '0;
  logic [3:0]  D0, D1, RUNNING, WRAP;

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] wrap;
    logic [3:0] run;
  } obs_t;

  obs_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 FSBCLK = ~FSBCLK;

  clk_div_gen #(.NCH(4), .DW(4)) dut (
    .FSBCLK (FSBCLK),
    .nRES   (nRES),
    .EN     (EN),
    .SYNC   (SYNC),
    .DIV    (DIV),
    .HI     (HI),
    .PH     (PH),
    .INV    (INV),
    .D0     (D0),
    .D1     (D1),
    .RUNNING(RUNNING),
    .WRAP   (WRAP)
  );

  function automatic obs_t mk(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] wrap, input logic [3:0] run);
    obs_t o;
    o.d0 = d0; o.d1 = d1; o.wrap = wrap; o.run = run;
    return o;
  endfunction

  // ch0 only, DIV=3 HI=4 INV=1: inverted, so low for cnt 0..1 and high for 2..3.
  function automatic obs_t pat_inv(input int c, input logic run);
    logic d;
    d = (c >= 2);
    return mk({3'b0, d}, {3'b0, d}, {3'b0, c == 3}, {3'b0, run});
  endfunction

  task automatic tick();
    @(posedge FSBCLK);
    #1;
  endtask

  task automatic prep(input logic [15:0] div, input logic [19:0] hi,
                      input logic [15:0] ph, input logic [3:0] inv);
    nRES = 1'b0; EN = '0; SYNC = 1'b0;
    DIV = div; HI = hi; PH = ph; INV = inv;
    @(negedge FSBCLK);
    nRES = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    obs_t got, exp;
    nRES = 1'b0; INV = 4'b1010;
    #2;
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
    got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_async got=%h exp=%h", got, exp); end
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
    tick();
    got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_held got=%h exp=%h", got, exp); end
    @(negedge FSBCLK);
    nRES = 1'b1;
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
    sb.push_back(mk(4'b1010, 4'b1010, 4'h0, 4'h0));
    sb.push_back(mk(4'b1010, 4'b1010, 4'h0, 4'h0));
    sb.push_back(mk(4'b0101, 4'b0101, 4'h0, 4'h0));
    for (int i = 0; i < 4; i++) begin
      if (i == 2) INV = 4'b0101;
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL idle_inv[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_legacy();
    obs_t got, exp;
    prep(16'h0011, {5'd0, 5'd1, 5'd2, 5'd2}, 16'h0000, 4'b0101);
    EN = 4'b0111;
    sb.push_back(mk(4'b0101, 4'b0101, 4'b0000, 4'b0111));
    for (int i = 0; i < 21; i++) begin
      if (i > 0)
        sb.push_back((i % 2 == 1) ? mk(4'b0010, 4'b0110, 4'b0100, 4'b0111)
                                  : mk(4'b0001, 4'b0101, 4'b0111, 4'b0111));
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL legacy[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_odd();
    obs_t got, exp;
    int c;
    prep(16'h0002, {15'd0, 5'd3}, 16'h0000, 4'b0000);
    EN = 4'b0001;
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h1));
    for (int i = 0; i < 10; i++) begin
      c = i - 1;
      if (i > 0)
        sb.push_back(mk({3'b0, (c % 3) < 2}, {3'b0, (c % 3) == 0}, {3'b0, (c % 3) == 2}, 4'h1));
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL odd[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_phase();
    obs_t got, exp;
    int c0, c1;
    prep(16'h0033, {10'd0, 5'd4, 5'd4}, 16'h0020, 4'b0000);
    EN = 4'b0001;
    tick(); tick();
    EN = 4'b0011;
    tick(); tick(); tick();
    SYNC = 1'b1;
    tick();
    SYNC = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      c0 = i % 4;
      c1 = (i + 2) % 4;
      sb.push_back(mk({2'b0, c1 < 2, c0 < 2}, {2'b0, c1 < 2, c0 < 2},
                      {2'b0, c1 == 3, c0 == 3}, 4'b0011));
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL phase[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_glitch();
    obs_t got, exp;
    prep(16'h0003, {15'd0, 5'd4}, 16'h0000, 4'b0000);
    EN = 4'b0001;
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h1));
    sb.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1));
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL glitch_start[%0d] got=%h exp=%h", i, got, exp); end
    end
    DIV = 16'h0007; HI = {15'd0, 5'd8};
    sb.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1));
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h1));
    sb.push_back(mk(4'h0, 4'h0, 4'h1, 4'h1));
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 8; c++)
        sb.push_back(mk({3'b0, c < 4}, {3'b0, c < 4}, {3'b0, c == 7}, 4'h1));
    for (int i = 0; i < 19; i++) begin
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL glitch[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_stop_restart();
    obs_t got, exp;
    int c;
    prep(16'h0003, {15'd0, 5'd4}, 16'h0000, 4'b0001);
    EN = 4'b0001;
    sb.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1));
    c = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 5) EN = 4'b0000;
      if (i == 6) EN = 4'b0001;
      if (i == 13) EN = 4'b0000;
      if (i >= 1 && i <= 17) begin
        sb.push_back(pat_inv(c, (i == 16 || i == 17) ? 1'b0 : 1'b1));
        c = (c + 1) % 4;
      end else if (i > 17) begin
        sb.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0));
      end
      // The final run stops after four outputs; the last of them carries cnt=3 with RUNNING low.
      if (i == 17) begin
        void'(sb.pop_back());
        sb.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0));
      end
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL stop_restart[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    int c;
    prep(16'h0003, {15'd0, 5'd4}, 16'h0001, 4'b0000);
    EN = 4'b0001;
    tick(); tick(); tick();
    #2;
    nRES = 1'b0;
    #1;
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0));
    got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
    if (got !== exp) begin n_bad++; $display("FAIL reset_mid got=%h exp=%h", got, exp); end
    @(negedge FSBCLK);
    nRES = 1'b1;
    sb.push_back(mk(4'h0, 4'h0, 4'h0, 4'h1));
    for (int i = 0; i < 6; i++) begin
      c = i % 4;
      sb.push_back(mk({3'b0, c < 2}, {3'b0, c < 2}, {3'b0, c == 3}, 4'h1));
    end
    // The first queued slot after the RUNNING-only cycle is cnt=PH=1, so drop the cnt=0 entry.
    void'(sb.pop_back());
    sb.delete(1);
    sb.insert(5, mk(4'h1, 4'h1, 4'h0, 4'h1));
    for (int i = 0; i < 6; i++) begin
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_restart[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_edges();
    obs_t got, exp;
    int a, b;
    prep(16'h0122, {5'd0, 5'd4, 5'd3, 5'd0}, 16'h0050, 4'b0001);
    EN = 4'b0111;
    sb.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0111));
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin
        a = (i - 1) % 3;
        b = (i - 1) % 2;
        sb.push_back(mk({1'b0, 1'b1, a < 2, 1'b1}, {1'b0, 1'b1, a == 0, 1'b1},
                        {1'b0, b == 1, a == 2, a == 2}, 4'b0111));
      end
      tick();
      got = {D0, D1, WRAP, RUNNING}; exp = sb.pop_front(); n_total++;
      if (got !== exp) begin n_bad++; $display("FAIL edges[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_odd();
    test_phase();
    test_glitch();
    test_stop_restart();
    test_reset_mid();
    test_edges();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
